pipe_stage_ctrl: RTL and testbench

Sequencing controller for a chain of NUM_STAGES pipeline register walls (enable D flip-flop banks with `enable` and `softReset`). It tracks a valid bit per stage and resolves upstream/downstream handshake, per-stage hazard holds and selective flushes. It drives each wall's `enable` and `softReset` so that payload advances, holds, bubbles or is killed correctly. It sits beside the datapath walls between the front end and issue, and also exports occupancy and stall-cycle statistics.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_stage_slot.sv | 59 +++++
 rtl/pipe_stage_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Purpose : shared constants and helpers for the pipeline stage controller.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package pipe_ctrl_pkg;

  // Default width of the saturating stall-cycle counter.
  localparam int STALL_CNT_W_DEF = 16;

  // Saturating increment on a 32-bit carrier. Callers cast the result back
  // to their own width, so counters up to 32 bits wide are supported.
  function automatic logic [31:0] sat_inc(input logic [31:0] i_val,
                                          input logic [31:0] i_max);
    return (i_val >= i_max) ? i_val : (i_val + 32'd1);
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// Purpose : valid bit plus advance/accept/load/clear logic for one pipeline wall.
// Latency : combinational strobes; valid bit updates on the same edge the wall loads.
// Backpressure : accept drops when the slot is full and cannot drain, or when it is killed.
//
// Ports:
//   i_clk, i_reset       clock and synchronous active-high reset
//   i_kill               flush or reset kill for this stage
//   i_stall              hazard hold for this stage
//   i_inc                valid payload offered by the previous stage (or upstream)
//   i_acc_nxt            next stage (or downstream) accepts this cycle
//   o_go                 this stage hands its payload onward this cycle
//   o_acc                this stage can take new payload this cycle
//   o_enable             load strobe for the wall
//   o_soft_reset         clear strobe for the wall
//   o_vld                registered valid bit
module pipe_stage_slot
  import pipe_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_kill,
  input  logic i_stall,
  input  logic i_inc,
  input  logic i_acc_nxt,
  output logic o_go,
  output logic o_acc,
  output logic o_enable,
  output logic o_soft_reset,
  output logic o_vld
);

  logic r_vld;

  assign o_go  = r_vld & ~i_stall & ~i_kill & i_acc_nxt;
  assign o_acc = ~i_kill & (~r_vld | o_go);

  assign o_enable = o_acc & i_inc;

  // A killed stage is cleared; a stage that drains with nothing arriving
  // behind it becomes a bubble and is cleared as well. Since o_acc already
  // contains ~i_kill and a draining stage only loads when i_inc is set,
  // load and clear can never be asserted together.
  assign o_soft_reset = i_kill | (o_go & ~i_inc);

  assign o_vld = r_vld;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld <= 1'b0;
    end else if (i_kill) begin
      r_vld <= 1'b0;
    end else if (o_enable) begin
      r_vld <= 1'b1;
    end else if (o_go) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Purpose : sequences NUM_STAGES register walls (load/clear strobes) with handshake, stalls and flushes.
// Latency : NUM_STAGES cycles from accept to out_valid; strobes are combinational.
// Backpressure : out_ready and per-stage stalls ripple back through the accept chain to in_ready.
//
// Ports:
//   clk, reset                clock and synchronous active-high reset
//   in_valid / in_ready       upstream handshake into stage 0
//   out_valid / out_ready     downstream handshake out of the last stage
//   stall                     per-stage hazard hold
//   flush, flush_mask         kill request and the stages it applies to
//   enable, softReset         per-wall load and clear strobes
//   stage_valid, occupancy    registered valid bits and their popcount
//   stall_cycles              saturating count of cycles with in_valid & !in_ready
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               out_ready,
  output logic                               out_valid,
  input  logic [NUM_STAGES-1:0]              stall,
  input  logic                               flush,
  input  logic [NUM_STAGES-1:0]              flush_mask,
  output logic [NUM_STAGES-1:0]              enable,
  output logic [NUM_STAGES-1:0]              softReset,
  output logic [NUM_STAGES-1:0]              stage_valid,
  output logic [$clog2(NUM_STAGES+1)-1:0]    occupancy,
  output logic [STALL_CNT_W-1:0]             stall_cycles
);

  localparam int OCC_W = $clog2(NUM_STAGES+1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_STAGES-1:0] w_kill;
  logic [NUM_STAGES-1:0] w_inc;
  logic [NUM_STAGES-1:0] w_go;
  logic [NUM_STAGES-1:0] w_acc;
  logic [NUM_STAGES-1:0] w_enable;
  logic [NUM_STAGES-1:0] w_soft_reset;
  logic [NUM_STAGES-1:0] w_vld;
  logic [NUM_STAGES:0]   w_rdy;
  logic [OCC_W-1:0]      w_occ;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Reset behaves as a kill of every stage: walls are cleared, nothing loads
  // and in_ready is low for as long as reset is held.
  assign w_kill = {NUM_STAGES{reset}} | ({NUM_STAGES{flush}} & flush_mask);

  // Accept look-ahead, computed from the last stage back to stage 0 in one
  // process. acc[i] = !kill[i] & (!v[i] | go[i]) with go folded in; each slot
  // gets its downstream accept from here instead of from its neighbour so
  // the chain does not loop through the slot outputs.
  always_comb begin
    logic [NUM_STAGES:0] w_chain;
    w_chain             = '0;
    w_chain[NUM_STAGES] = out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      w_chain[i] = ~w_kill[i] & (~w_vld[i] | (~stall[i] & w_chain[i+1]));
    end
    w_rdy = w_chain;
  end

  // Payload offered to stage i is whatever stage i-1 hands onward.
  assign w_inc = {w_go[NUM_STAGES-2:0], in_valid};

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_slot
    pipe_stage_slot u_slot (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_kill       (w_kill[gi]),
      .i_stall      (stall[gi]),
      .i_inc        (w_inc[gi]),
      .i_acc_nxt    (w_rdy[gi+1]),
      .o_go         (w_go[gi]),
      .o_acc        (w_acc[gi]),
      .o_enable     (w_enable[gi]),
      .o_soft_reset (w_soft_reset[gi]),
      .o_vld        (w_vld[gi])
    );
  end

  // Popcount of the registered valid bits.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_occ = w_occ + OCC_W'(w_vld[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !w_acc[0]) begin
      r_stall_cnt <= STALL_CNT_W'(sat_inc(32'(r_stall_cnt), 32'(CNT_MAX)));
    end
  end

  // Consistency checks: the look-ahead chain must agree with the slots,
  // load and clear are exclusive, and the last stage only emits into a
  // ready consumer.
  always_comb begin
    assert (w_acc == w_rdy[NUM_STAGES-1:0]);
    assert ((w_enable & w_soft_reset) == '0);
    assert (!w_go[NUM_STAGES-1] || out_ready);
  end

  assign in_ready     = w_acc[0];
  assign out_valid    = w_vld[NUM_STAGES-1];
  assign enable       = w_enable;
  assign softReset    = w_soft_reset;
  assign stage_valid  = w_vld;
  assign occupancy    = w_occ;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Purpose : directed self-checking bench for pipe_stage_ctrl (4 stages, 4-bit stall counter).
// Latency : n/a (bench).
// Backpressure : n/a (bench).
module tb_pipe_stage_ctrl;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] stall;
  logic       flush;
  logic [3:0] flush_mask;
  logic [3:0] enable;
  logic [3:0] softReset;
  logic [3:0] stage_valid;
  logic [2:0] occupancy;
  logic [3:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  pipe_stage_ctrl #(
    .NUM_STAGES  (4),
    .STALL_CNT_W (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .stall        (stall),
    .flush        (flush),
    .flush_mask   (flush_mask),
    .enable       (enable),
    .softReset    (softReset),
    .stage_valid  (stage_valid),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle window: just past the rising edge.
  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rst, input logic iv, input logic ordy,
                       input logic [3:0] stl, input logic fl, input logic [3:0] msk);
    reset      = rst;
    in_valid   = iv;
    out_ready  = ordy;
    stall      = stl;
    flush      = fl;
    flush_mask = msk;
    #1;
  endtask

  logic [3:0] exp_en  [0:5];
  logic [2:0] exp_occ [0:5];
  logic       exp_ov  [0:5];

  initial begin
    exp_en  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    exp_occ = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_ov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset held: strobes forced before the first edge.
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    chk("rst_enable", 32'(enable), 32'h0);
    chk("rst_softreset", 32'(softReset), 32'hF);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    next_cyc();

    // Post-reset state.
    drive(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000);
    chk("post_rst_valid", 32'(stage_valid), 32'h0);
    chk("post_rst_occ", 32'(occupancy), 32'h0);
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk("post_rst_stall_cnt", 32'(stall_cycles), 32'h0);
    next_cyc();

    // Stream: fill then steady one-per-cycle flow.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000);
      chk($sformatf("stream_en_%0d", k), 32'(enable), 32'(exp_en[k]));
      chk($sformatf("stream_occ_%0d", k), 32'(occupancy), 32'(exp_occ[k]));
      chk($sformatf("stream_ov_%0d", k), 32'(out_valid), 32'(exp_ov[k]));
      chk($sformatf("stream_in_ready_%0d", k), 32'(in_ready), 32'h1);
      next_cyc();
    end

    // Back-pressure: full pipe, downstream not ready for 3 cycles.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
      chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
      chk($sformatf("bp_enable_%0d", k), 32'(enable), 32'h0);
      chk($sformatf("bp_occ_%0d", k), 32'(occupancy), 32'h4);
      chk($sformatf("bp_stall_cnt_%0d", k), 32'(stall_cycles), 32'(k));
      next_cyc();
    end
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000);
    chk("bp_stall_cnt_end", 32'(stall_cycles), 32'h3);
    chk("bp_resume_enable", 32'(enable), 32'hF);
    next_cyc();

    // Mid stall on stage 1 for two cycles: stages 2-3 drain as bubbles.
    drive(1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 4'b0000);
    chk("ms0_enable", 32'(enable), 32'b1000);
    chk("ms0_softreset", 32'(softReset), 32'b0100);
    chk("ms0_in_ready", 32'(in_ready), 32'h0);
    next_cyc();
    drive(1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 4'b0000);
    chk("ms1_valid", 32'(stage_valid), 32'b1011);
    chk("ms1_enable", 32'(enable), 32'b0000);
    chk("ms1_softreset", 32'(softReset), 32'b1000);
    next_cyc();
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000);
    chk("ms2_valid", 32'(stage_valid), 32'b0011);
    chk("ms2_enable", 32'(enable), 32'b0111);
    chk("ms2_softreset", 32'(softReset), 32'b0000);
    chk("ms2_stall_cnt", 32'(stall_cycles), 32'h5);
    next_cyc();
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000);
    chk("ms3_valid", 32'(stage_valid), 32'b0111);
    chk("ms3_enable", 32'(enable), 32'b1111);
    next_cyc();

    // Selective flush of stages 0-1 with the pipe full and held.
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0011);
    chk("sf_pre_valid", 32'(stage_valid), 32'hF);
    chk("sf_softreset", 32'(softReset), 32'b0011);
    chk("sf_enable", 32'(enable), 32'b0000);
    chk("sf_in_ready", 32'(in_ready), 32'h0);
    next_cyc();
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    chk("sf_post_valid", 32'(stage_valid), 32'b1100);
    chk("sf_post_occ", 32'(occupancy), 32'h2);
    chk("sf_refill_enable", 32'(enable), 32'b0001);
    chk("sf_stall_cnt", 32'(stall_cycles), 32'h6);
    next_cyc();

    // Reset with three stages occupied.
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    chk("mr_occ", 32'(occupancy), 32'h3);
    chk("mr_softreset", 32'(softReset), 32'hF);
    chk("mr_enable", 32'(enable), 32'h0);
    chk("mr_in_ready", 32'(in_ready), 32'h0);
    next_cyc();
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000);
    chk("mr_post_valid", 32'(stage_valid), 32'h0);
    chk("mr_post_occ", 32'(occupancy), 32'h0);
    chk("mr_post_out_valid", 32'(out_valid), 32'h0);
    chk("mr_post_stall_cnt", 32'(stall_cycles), 32'h0);
    chk("mr_post_enable", 32'(enable), 32'b0001);
    next_cyc();

    // Flush of every stage.
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b1111);
    chk("fa_pre_valid", 32'(stage_valid), 32'b0001);
    chk("fa_in_ready", 32'(in_ready), 32'h0);
    chk("fa_softreset", 32'(softReset), 32'hF);
    chk("fa_enable", 32'(enable), 32'h0);
    next_cyc();

    // Saturation: keep offering with downstream blocked.
    for (int k = 0; k < 30; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
      if (k == 0) begin
        chk("fa_post_valid", 32'(stage_valid), 32'h0);
        chk("sat_start_cnt", 32'(stall_cycles), 32'h1);
      end
      if (k == 3) chk("sat_fill_in_ready", 32'(in_ready), 32'h1);
      if (k == 4) chk("sat_full_in_ready", 32'(in_ready), 32'h0);
      if (k == 10) chk("sat_mid_cnt", 32'(stall_cycles), 32'h7);
      next_cyc();
    end
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    chk("sat_cnt_a", 32'(stall_cycles), 32'hF);
    next_cyc();
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    chk("sat_cnt_b", 32'(stall_cycles), 32'hF);
    chk("sat_occ", 32'(occupancy), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a run that never completes.
  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
